// File: rtl/puf_key_harvester.sv
// puf_key_harvester: majority-voted arbiter-PUF key harvest, whitened with seed_key.
// Build option PUF_MAJORITY_EN: when defined, each key bit is the majority of VOTES
// samples; when undefined, each bit is a single sample and the vote counters vanish.
module puf_key_harvester #(
  parameter int              KEY_W     = 128,
  parameter int              CHAL_W    = 32,
  parameter logic [CHAL_W-1:0] CHAL_SEED = 32'hACE1_2468,
  parameter int              SETTLE    = 4,
  parameter int              VOTES     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KEY_W-1:0]  seed_key,
  output logic [CHAL_W-1:0] challenge,
  output logic              puf_fire,
  input  logic              puf_resp,
  output logic [KEY_W-1:0]  key_out,
  output logic              enable,
  output logic              busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_SHIFT  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam int BW = $clog2(KEY_W);
  localparam int WW = $clog2(SETTLE + 1);
  localparam logic [CHAL_W-1:0] TAPS = CHAL_W'(32'h8020_0003);

  if (VOTES < 1 || VOTES % 2 == 0 || SETTLE < 1 || CHAL_SEED == '0) begin : g_param_check
    $error("puf_key_harvester: VOTES must be odd and >=1, SETTLE >=1, CHAL_SEED nonzero");
  end

  logic [2:0]        r_state;
  logic [CHAL_W-1:0] r_lfsr;
  logic [BW-1:0]     r_bit;
  logic [WW-1:0]     r_wait;
  logic [KEY_W-1:0]  r_raw;
  logic [KEY_W-1:0]  r_key;
  logic              r_enable;
  logic [CHAL_W-1:0] w_lfsr_nxt;
  logic              w_bit;

`ifdef PUF_MAJORITY_EN
  localparam int OW = $clog2(VOTES + 1);
  logic [OW-1:0] r_votes;
  logic [OW-1:0] r_ones;
  assign w_bit = r_ones > OW'(VOTES / 2);
`else
  logic r_samp;
  assign w_bit = r_samp;
`endif

  assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign challenge  = r_lfsr;
  assign puf_fire   = r_state == S_LAUNCH;
  assign busy       = r_state != S_IDLE && r_state != S_DONE;
  assign key_out    = r_key;
  assign enable     = r_enable;

  // Harvest FSM: launch/settle/sample per vote, shift one key bit per SHIFT, latch whitened key once in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_lfsr   <= CHAL_SEED;
      r_bit    <= '0;
      r_wait   <= '0;
      r_raw    <= '0;
      r_key    <= '0;
      r_enable <= 1'b0;
`ifdef PUF_MAJORITY_EN
      r_votes  <= '0;
      r_ones   <= '0;
`else
      r_samp   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_LAUNCH;
          r_bit   <= '0;
          r_raw   <= '0;
`ifdef PUF_MAJORITY_EN
          r_votes <= '0;
          r_ones  <= '0;
`endif
        end
        S_LAUNCH: begin
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wait  <= r_wait + WW'(1);
          r_state <= (r_wait == WW'(SETTLE - 1)) ? S_SAMPLE : S_WAIT;
        end
        S_SAMPLE: begin
`ifdef PUF_MAJORITY_EN
          r_ones  <= r_ones + OW'(puf_resp);
          r_votes <= r_votes + OW'(1);
          r_state <= (r_votes == OW'(VOTES - 1)) ? S_SHIFT : S_LAUNCH;
`else
          r_samp  <= puf_resp;
          r_state <= S_SHIFT;
`endif
        end
        S_SHIFT: begin
          r_raw   <= {r_raw[KEY_W-2:0], w_bit};
          r_lfsr  <= w_lfsr_nxt;
`ifdef PUF_MAJORITY_EN
          r_votes <= '0;
          r_ones  <= '0;
`endif
          r_bit   <= (r_bit == BW'(KEY_W - 1)) ? r_bit : r_bit + BW'(1);
          r_state <= (r_bit == BW'(KEY_W - 1)) ? S_DONE : S_LAUNCH;
        end
        S_DONE: if (!r_enable) begin
          r_key    <= r_raw ^ seed_key;
          r_enable <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_key_harvester.sv
// tb_puf_key_harvester: scoreboard bench for puf_key_harvester (both PUF_MAJORITY_EN builds).
module tb_puf_key_harvester;
  localparam int KEY_W  = 128;
  localparam logic [31:0] CSEED = 32'hACE1_2468;
`ifdef PUF_MAJORITY_EN
  localparam int NV    = 5;
  localparam int LAT   = 3969;
  localparam int ABORT = 1000;
`else
  localparam int NV    = 1;
  localparam int LAT   = 897;
  localparam int ABORT = 400;
`endif
  localparam logic [127:0] SEED = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] INV  = 128'hd481eae9_d7512d59_5408ea77_f630b0c3;
  localparam logic [127:0] ALT  = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;

  logic clk = 0, reset = 1, start = 0, puf_resp = 0;
  logic [127:0] seed_key = '0;
  logic [31:0]  challenge;
  logic         puf_fire, enable, busy;
  logic [127:0] key_out;

  puf_key_harvester dut (
    .clk(clk), .reset(reset), .start(start), .seed_key(seed_key),
    .challenge(challenge), .puf_fire(puf_fire), .puf_resp(puf_resp),
    .key_out(key_out), .enable(enable), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0, fires = 0, mode = 0;

  typedef struct {
    string        name;
    logic [127:0] key;
    int           at;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: on each rising enable, pop the expected key and arrival cycle.
  initial begin
    logic pe;
    exp_t e;
    pe = 0;
    forever begin
      @(negedge clk);
      if (enable && !pe) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_enable: got enable=1 expected no completion");
        end else begin
          e = q.pop_front();
          check({e.name, "_key"}, key_out, e.key);
          check({e.name, "_latency"}, 128'(cyc), 128'(e.at));
        end
      end
      pe = enable;
    end
  end

  // PUF model: counts fires, checks challenge against the LFSR sequence, drives responses.
  initial begin
    int k, b, v;
    logic [31:0] m;
    k = 0;
    m = CSEED;
    forever begin
      @(negedge clk);
      if (!reset) begin
        k = 0;
        m = CSEED;
      end else if (puf_fire) begin
        check("challenge_seq", 128'(challenge), 128'(m));
        check("challenge_nonzero", 128'(challenge == 0), 128'(0));
        b = k / NV;
        v = k % NV;
        if (mode == 2) puf_resp = (NV == 1) ? (b % 2 == 0) : (v < ((b % 2 == 0) ? 3 : 2));
        else puf_resp = (mode == 1);
        k++;
        if (k % NV == 0) m = {1'b0, m[31:1]} ^ (m[0] ? 32'h8020_0003 : 32'h0);
      end
      fires = k;
    end
  end

  task automatic do_reset(input logic hold_start);
    @(negedge clk);
    reset = 0;
    start = hold_start;
    repeat (3) @(negedge clk);
    reset = 1;
  endtask

  task automatic wait_enable(input string nm);
    int t;
    t = 0;
    while (!enable && t < LAT + 100) begin
      @(negedge clk);
      t++;
    end
    if (!enable) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got enable=0 expected enable within %0d cycles", nm, LAT);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string nm, input int m, input logic [127:0] sk, input logic [127:0] ek);
    mode = m;
    seed_key = sk;
    do_reset(0);
    @(negedge clk);
    start = 1;
    q.push_back('{nm, ek, cyc + 1 + LAT});
    @(negedge clk);
    start = 0;
    wait_enable(nm);
  endtask

  initial begin
    #2 reset = 0;
    repeat (2) @(negedge clk);
    check("rst_challenge", 128'(challenge), 128'(CSEED));
    check("rst_fire", 128'(puf_fire), 128'(0));
    check("rst_key", key_out, 128'(0));
    check("rst_enable", 128'(enable), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));

    run("resp0", 0, SEED, SEED);
    check("fire_count", 128'(fires), 128'(KEY_W * NV));
    run("resp1", 1, SEED, INV);
    run("alt", 2, '0, ALT);

    mode = 0;
    seed_key = SEED;
    do_reset(0);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (ABORT - 1) @(negedge clk);
    check("pre_abort_busy", 128'(busy), 128'(1));
    #2 reset = 0;
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_enable", 128'(enable), 128'(0));
    check("abort_fire", 128'(puf_fire), 128'(0));
    check("abort_challenge", 128'(challenge), 128'(CSEED));
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    start = 1;
    q.push_back('{"restart", SEED, cyc + 1 + LAT});
    @(negedge clk);
    start = 0;
    wait_enable("restart");
    check("restart_fires", 128'(fires), 128'(KEY_W * NV));

    mode = 1;
    seed_key = SEED;
    do_reset(1);
    q.push_back('{"held", INV, cyc + 1 + LAT});
    wait_enable("held");
    repeat (50) @(negedge clk);
    check("held_busy", 128'(busy), 128'(0));
    check("held_key", key_out, INV);
    check("held_enable", 128'(enable), 128'(1));
    check("held_fires", 128'(fires), 128'(KEY_W * NV));
    start = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (20) @(negedge clk);
    check("repulse_busy", 128'(busy), 128'(0));
    check("repulse_key", key_out, INV);
    check("repulse_fires", 128'(fires), 128'(KEY_W * NV));
    check("queue_drained", 128'(q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish before 3ms");
    $fatal(1, "watchdog");
  end
endmodule
